// File: rtl/adc_acq_ctrl_pkg.sv
// adc_acq_ctrl_pkg: FSM encoding, default widths and source numbering shared
// by the ADC acquisition front end and the downstream dispatcher.
package adc_acq_ctrl_pkg;
    localparam int W_DATA_DEF = 18;
    localparam int W_SRC_DEF  = 5;
    localparam int N_ADC_DEF  = 8;
    // Sources 0..N_ADC_DEF-1 are ADC channels; all-ones marks an empty slot.
    localparam logic [W_SRC_DEF-1:0] NULL_SRC = '1;
    typedef enum logic [2:0] {IDLE, CONVST, WAIT_HI, WAIT_LO, READ} state_t;
endpackage

// File: rtl/adc_serial_rx.sv
// adc_serial_rx: SCLK generator and MSB-first shift register for one read
// frame; done strobes for one cycle after each complete word.
module adc_serial_rx
    import adc_acq_ctrl_pkg::*;
#(
    parameter int W_DATA  = W_DATA_DEF,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              run,
    input  logic              stop,
    input  logic              sdata,
    output logic              sclk,
    output logic              fall,
    output logic              capture,
    output logic              done,
    output logic [W_DATA-1:0] word
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(W_DATA + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(W_DATA - 1);
    logic [CW-1:0] cnt;
    logic [BW-1:0] bits;
    logic [W_DATA-2:0] shift;
    logic rise;
    // rise/fall mark the clk_in edge on which the registered sclk toggles
    assign rise = run && !sclk && cnt == C_LAST;
    assign fall = sclk && cnt == C_LAST;
    assign capture = rise && bits == B_LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk  <= 1'b1;
            cnt   <= '0;
            bits  <= '0;
            shift <= '0;
            done  <= 1'b0;
            word  <= '0;
        end else begin
            done <= capture;
            if (capture) word <= {shift, sdata};
            if (start) begin
                sclk <= 1'b0;
                cnt  <= '0;
                bits <= '0;
            end else if (!run || stop) begin
                sclk <= 1'b1;
                cnt  <= '0;
                bits <= '0;
            end else begin
                cnt <= cnt == C_LAST ? '0 : cnt + 1'b1;
                if (cnt == C_LAST) sclk <= ~sclk;
                if (rise) begin
                    shift <= {shift[W_DATA-3:0], sdata};
                    bits  <= capture ? '0 : bits + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/adc_acq_ctrl.sv
// adc_acq_ctrl: periodic trigger, CONVST/BUSY handshake and channel sequencing
// for an 8-channel simultaneous-sampling serial ADC.
module adc_acq_ctrl
    import adc_acq_ctrl_pkg::*;
#(
    parameter int W_DATA   = W_DATA_DEF,
    parameter int W_SRC    = W_SRC_DEF,
    parameter int N_ADC    = N_ADC_DEF,
    parameter int CLK_DIV  = 2,
    parameter int T_CYCLE  = 2000,
    parameter int CONVST_W = 4,
    parameter int BUSY_TO  = 500
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              en_in,
    input  logic [2:0]        os_in,
    input  logic              adc_busy_in,
    input  logic              adc_data_in,
    output logic              adc_convst_out,
    output logic              adc_cs_out,
    output logic              adc_sclk_out,
    output logic [2:0]        adc_os_out,
    output logic              dv_out,
    output logic [W_SRC-1:0]  src_out,
    output logic [W_DATA-1:0] data_out,
    output logic              overrun_out,
    output logic              timeout_out
);
    localparam int TW = $clog2(T_CYCLE + 1);
    localparam int WW = $clog2((BUSY_TO > CONVST_W ? BUSY_TO : CONVST_W) + 1);
    localparam int NW = $clog2(N_ADC + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(T_CYCLE - 1);
    localparam logic [WW-1:0] CV_LAST = WW'(CONVST_W - 1);
    localparam logic [WW-1:0] TO_LAST = WW'(BUSY_TO - 1);
    localparam logic [NW-1:0] CH_END  = NW'(N_ADC);
    state_t state;
    logic [TW-1:0] tcnt;
    logic [WW-1:0] wcnt;
    logic [NW-1:0] ch;
    logic busy_m, busy_s, trigger, start, run, stop, fall, capture;
    assign trigger = en_in && tcnt == '0;
    assign start = state == WAIT_LO && !busy_s;
    assign run = state == READ;
    // the frame ends on the SCLK fall that follows the last channel's last bit
    assign stop = run && fall && ch == CH_END;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tcnt   <= '0;
            busy_m <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            tcnt   <= !en_in || tcnt == T_LAST ? '0 : tcnt + 1'b1;
            busy_m <= adc_busy_in;
            busy_s <= busy_m;
        end
    end
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            wcnt           <= '0;
            ch             <= '0;
            src_out        <= '0;
            adc_convst_out <= 1'b0;
            adc_cs_out     <= 1'b1;
            adc_os_out     <= '0;
            overrun_out    <= 1'b0;
            timeout_out    <= 1'b0;
        end else begin
            overrun_out <= trigger && state != IDLE;
            timeout_out <= 1'b0;
            case (state)
                IDLE: begin
                    adc_os_out <= os_in;
                    wcnt       <= '0;
                    if (trigger) begin
                        state          <= CONVST;
                        adc_convst_out <= 1'b1;
                    end
                end
                CONVST: begin
                    if (wcnt == CV_LAST) begin
                        state          <= WAIT_HI;
                        adc_convst_out <= 1'b0;
                        wcnt           <= '0;
                    end else wcnt <= wcnt + 1'b1;
                end
                WAIT_HI: begin
                    if (busy_s) begin
                        state <= WAIT_LO;
                        wcnt  <= '0;
                    end else if (wcnt == TO_LAST) begin
                        state       <= IDLE;
                        timeout_out <= 1'b1;
                    end else wcnt <= wcnt + 1'b1;
                end
                WAIT_LO: begin
                    if (!busy_s) begin
                        state      <= READ;
                        adc_cs_out <= 1'b0;
                        ch         <= '0;
                    end else if (wcnt == TO_LAST) begin
                        state       <= IDLE;
                        timeout_out <= 1'b1;
                    end else wcnt <= wcnt + 1'b1;
                end
                READ: begin
                    if (capture) begin
                        src_out <= W_SRC'(ch);
                        ch      <= ch + 1'b1;
                    end
                    if (stop) begin
                        state      <= IDLE;
                        adc_cs_out <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    adc_serial_rx #(.W_DATA(W_DATA), .CLK_DIV(CLK_DIV)) u_rx (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .start   (start),
        .run     (run),
        .stop    (stop),
        .sdata   (adc_data_in),
        .sclk    (adc_sclk_out),
        .fall    (fall),
        .capture (capture),
        .done    (dv_out),
        .word    (data_out)
    );
endmodule

// File: tb/tb_adc_acq_ctrl.sv
// tb_adc_acq_ctrl: two controller instances (nominal period and a short
// period that forces overruns) driven by a behavioural ADC model.
module tb_adc_acq_ctrl;
    typedef struct packed {
        logic [4:0]  src;
        logic [17:0] data;
    } exp_t;
    typedef struct {
        logic [2:0]  os;
        logic [17:0] base;
        logic [17:0] step;
        int          hot;
        logic [17:0] hotv;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n;
    logic en [2];
    logic [2:0] os_in [2];
    logic [2:0] os_out [2];
    logic busy [2], sdata [2], convst [2], cs [2], sclk [2], dv [2];
    logic overrun [2], timeout [2], stuck [2];
    logic [4:0] src [2];
    logic [17:0] data [2];
    logic [17:0] words [2][8];
    vec_t vecs [4];
    exp_t q0 [$];
    int checks = 0, errors = 0, cyc = 0;
    int nd0 = 0, last_dv0 = 0, cslen0 = 0, frame_len0 = 0, frame_nd0 = 0, frames0 = 0;
    int cv_fall0 = 0, to_at0 = 0, to_cnt0 = 0, dv0_total = 0, ov0 = 0;
    int frames1 = 0, dv1_total = 0, ov1 = 0;
    logic cs0_d = 1'b1, cs1_d = 1'b1, cv0_d = 1'b0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : u
        int bcnt = 0;
        int idx = 0;
        logic cv_d = 1'b0;
        adc_acq_ctrl #(.T_CYCLE(g == 0 ? 2000 : 500)) dut (
            .clk_in         (clk),
            .rst_in         (rst_n),
            .en_in          (en[g]),
            .os_in          (os_in[g]),
            .adc_busy_in    (busy[g]),
            .adc_data_in    (sdata[g]),
            .adc_convst_out (convst[g]),
            .adc_cs_out     (cs[g]),
            .adc_sclk_out   (sclk[g]),
            .adc_os_out     (os_out[g]),
            .dv_out         (dv[g]),
            .src_out        (src[g]),
            .data_out       (data[g]),
            .overrun_out    (overrun[g]),
            .timeout_out    (timeout[g])
        );
        // ADC: busy high 100 cycles after a CONVST rise; DOUT advances after each SCLK rise
        always @(posedge clk) begin
            cv_d <= convst[g];
            if (convst[g] && !cv_d && !stuck[g]) bcnt <= 100;
            else if (bcnt > 0) bcnt <= bcnt - 1;
        end
        always @(posedge cs[g] or posedge sclk[g]) idx = cs[g] ? 0 : idx + 1;
        assign busy[g] = bcnt > 0;
        assign sdata[g] = !cs[g] && idx < 144 ? words[g][idx / 18][17 - idx % 18] : 1'b0;
    end
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask
    function automatic logic [17:0] wd(input int v, input int k);
        return k == vecs[v].hot ? vecs[v].hotv : 18'(vecs[v].base + vecs[v].step * k);
    endfunction
    task automatic load_frame(input int v);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            words[0][k] = wd(v, k);
            e.src = 5'(k);
            e.data = wd(v, k);
            q0.push_back(e);
        end
        os_in[0] = vecs[v].os;
        @(negedge clk) en[0] = 1'b1;
        @(negedge clk) en[0] = 1'b0;
    endtask
    task automatic run_frame(input int v);
        int f;
        logic [2:0] nos;
        nos = ~vecs[v].os;
        load_frame(v);
        f = frames0;
        for (int i = 0; i < 400 && cs[0]; i++) @(negedge clk);
        chk("cs_fell", cs[0], 0);
        os_in[0] = nos;
        repeat (300) @(negedge clk);
        chk("os_held", os_out[0], vecs[v].os);
        for (int i = 0; i < 1000 && frames0 == f; i++) @(negedge clk);
        chk("frame_done", frames0, f + 1);
        chk("cs_low_len", frame_len0, 576);
        chk("dv_per_frame", frame_nd0, 8);
        chk("queue_empty", q0.size(), 0);
        repeat (2) @(negedge clk);
        chk("os_loaded", os_out[0], nos);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int t, d;
        exp_t e;
        rst_n = 1'b0;
        en = '{1'b0, 1'b0};
        os_in = '{3'd0, 3'd0};
        stuck = '{1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            words[0][k] = '0;
            words[1][k] = 18'h10000 + 18'(k);
        end
        vecs[0] = '{os: 3'd1, base: 18'h10000, step: 18'd1, hot: -1, hotv: 18'h0};
        vecs[1] = '{os: 3'd2, base: 18'h0,     step: 18'd0, hot: 3,  hotv: 18'h20001};
        vecs[2] = '{os: 3'd5, base: 18'h3FFFF, step: 18'd0, hot: -1, hotv: 18'h0};
        vecs[3] = '{os: 3'd6, base: 18'h2AAAA, step: 18'd0, hot: 7,  hotv: 18'h15555};
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (dv[0]) begin
                    chk("dv0_queued", q0.size() != 0, 1);
                    if (q0.size() != 0) begin
                        e = q0.pop_front();
                        chk("dv0_src", src[0], e.src);
                        chk("dv0_data", data[0], e.data);
                    end
                    if (nd0 > 0) chk("dv0_spacing", cyc - last_dv0, 72);
                    chk("dv0_in_frame", cs[0], 0);
                    last_dv0 = cyc;
                    nd0++;
                    dv0_total++;
                end
                if (!cs[0]) cslen0++;
                else if (!cs0_d) begin
                    frame_len0 = cslen0;
                    frame_nd0 = nd0;
                    cslen0 = 0;
                    nd0 = 0;
                    frames0++;
                end
                cs0_d = cs[0];
                if (cv0_d && !convst[0]) cv_fall0 = cyc;
                cv0_d = convst[0];
                if (timeout[0]) begin
                    to_at0 = cyc;
                    to_cnt0++;
                end
                if (overrun[0]) ov0++;
                if (dv[1]) begin
                    chk("dv1_data", data[1], 18'h10000 + src[1]);
                    chk("dv1_in_frame", cs[1], 0);
                    dv1_total++;
                end
                if (cs[1] && !cs1_d) frames1++;
                cs1_d = cs[1];
                if (overrun[1]) ov1++;
            end
        join_none
        repeat (3) @(negedge clk);
        chk("rst_cs", cs[0], 1);
        chk("rst_sclk", sclk[0], 1);
        chk("rst_convst", convst[0], 0);
        chk("rst_dv", dv[0], 0);
        chk("rst_src", src[0], 0);
        chk("rst_data", data[0], 0);
        chk("rst_os", os_out[0], 0);
        chk("rst_overrun", overrun[1], 0);
        chk("rst_timeout", timeout[0], 0);
        rst_n = 1'b1;
        for (int v = 0; v < 4; v++) run_frame(v);
        // busy never rises: timeout, no data, then a normal frame
        stuck[0] = 1'b1;
        t = to_cnt0;
        d = dv0_total;
        os_in[0] = 3'd0;
        @(negedge clk) en[0] = 1'b1;
        @(negedge clk) en[0] = 1'b0;
        for (int i = 0; i < 1000 && to_cnt0 == t; i++) @(negedge clk);
        chk("timeout_pulse", to_cnt0, t + 1);
        chk("timeout_delay", to_at0 - cv_fall0, 500);
        repeat (5) @(negedge clk);
        chk("timeout_one_cycle", to_cnt0, t + 1);
        chk("timeout_no_dv", dv0_total, d);
        chk("timeout_cs_high", cs[0], 1);
        stuck[0] = 1'b0;
        run_frame(1);
        // asynchronous reset after the third word of a frame
        load_frame(0);
        for (int i = 0; i < 1000 && nd0 != 3; i++) @(negedge clk);
        chk("third_dv_seen", nd0, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs", cs[0], 1);
        chk("arst_sclk", sclk[0], 1);
        chk("arst_dv", dv[0], 0);
        chk("arst_src", src[0], 0);
        chk("arst_data", data[0], 0);
        chk("arst_os", os_out[0], 0);
        q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(0);
        // short period: every other trigger lands mid-frame
        @(negedge clk) en[1] = 1'b1;
        repeat (2900) @(negedge clk);
        en[1] = 1'b0;
        repeat (1000) @(negedge clk);
        chk("ov1_pulses", ov1, 3);
        chk("ov1_frames", frames1, 3);
        chk("ov1_dv", dv1_total, 24);
        chk("ov0_none", ov0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_acq_ctrl.md
Name: adc_acq_ctrl

Overview:
- Upstream acquisition stage for the PID pipeline.
- Periodically triggers an 8-channel, 18-bit simultaneous-sampling serial ADC, waits for conversion, clocks out all channel words, and emits one {src, data} word per channel with a one-cycle valid strobe.
- Output feeds the instruction dispatcher's input FIFO directly (dv_out -> dv_in, src_out -> fifo source, data_out -> data).

Parameters:
- W_DATA, 18, ADC word width (two's complement, passed raw).
- W_SRC, 5, source index width.
- N_ADC, 8, channels read per conversion.
- CLK_DIV, 2, clk_in cycles per SCLK half-period (>=1).
- T_CYCLE, 2000, clk_in cycles between conversion triggers.
- CONVST_W, 4, CONVST high-pulse width in clk_in cycles.
- BUSY_TO, 500, maximum cycles to wait for busy to rise or fall.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- en_in  in  1  acquisition enable.
- os_in  in  3  oversampling ratio request.
- adc_busy_in  in  1  ADC BUSY.
- adc_data_in  in  1  ADC DOUTA serial data.
- adc_convst_out  out  1  conversion start, active-high pulse.
- adc_cs_out  out  1  chip select, active-low.
- adc_sclk_out  out  1  serial clock, idles high.
- adc_os_out  out  3  registered oversampling pins.
- dv_out  out  1  one-cycle data-valid strobe.
- src_out  out  W_SRC  channel index of data_out.
- data_out  out  W_DATA  channel sample.
- overrun_out  out  1  one-cycle pulse: trigger missed, previous frame still active.
- timeout_out  out  1  one-cycle pulse: busy handshake timed out.

Behaviour:
- Reset (rst_in low, asynchronous):
  - convst=0, cs=1, sclk=1, os=0, dv=0, src=0, data=0, overrun=0, timeout=0.
  - FSM goes to IDLE; cycle timer and bit/channel counters are cleared.
  - Reset asserted mid-frame aborts the frame immediately and emits no partial word.
- Cycle timer:
  - Free-runs 0..T_CYCLE-1 while en_in=1; holds at 0 while en_in=0.
  - At count 0 with en_in=1, a trigger is raised.
  - If a trigger is raised while the FSM is not in IDLE: the trigger is dropped and overrun_out pulses for that cycle.
- adc_os_out:
  - Loads os_in only in IDLE.
  - Held constant from CONVST until the frame returns to IDLE.
- FSM:
  - IDLE: on trigger -> CONVST.
  - CONVST: convst=1 for CONVST_W cycles -> WAIT_HI.
  - WAIT_HI: wait for adc_busy_in=1 -> WAIT_LO. If BUSY_TO cycles elapse: timeout pulse -> IDLE.
  - WAIT_LO: wait for adc_busy_in=0 -> READ with cs=0. BUSY_TO timeout behaves as in WAIT_HI.
  - READ:
    - sclk goes low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - adc_data_in is sampled into the shift register in the clk_in cycle where sclk rises.
    - Bits arrive MSB first; channel 0 first.
    - After bit W_DATA-1 of channel k: on the next cycle dv_out=1, src_out=k, data_out=word.
    - src_out and data_out hold their values until the next dv.
    - After channel N_ADC-1 is emitted: cs=1, sclk=1 -> IDLE.
- Latency: frame length from CS low to CS high is N_ADC*W_DATA*2*CLK_DIV cycles (defaults: 576).
- Throughput: dv spacing within a frame is exactly W_DATA*2*CLK_DIV cycles (72 at defaults). The downstream FIFO is never back-pressured; no ready input exists.
- en_in deasserted mid-frame: the current frame completes; no new triggers are raised.
- busy_in is double-flop synchronised before use.
- adc_data_in is used directly; it is stable at the SCLK rising edge by ADC timing.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, CONVST, WAIT_HI, WAIT_LO, READ).
  - W_DATA, W_SRC, N_ADC defaults.
  - The NULL_SRC constant shared with the dispatcher, so source numbering 0..N_ADC-1 is common.
- One sub-module, adc_serial_rx:
  - Contains the SCLK generator, bit counter, shift register and word-done strobe.
  - Top level keeps the cycle timer, FSM, busy handshake and channel counter.

Test Plan:
- Nominal frame: ADC model with busy high 100 cycles and channel k = 18'h1_0000+k; en_in=1 -> 8 dv pulses, src 0..7, data 0x10000..0x10007, spacing 72 cycles, cs low for exactly 576 cycles.
- Sign/MSB order: channel 3 = 18'h2_0001, all others 0 -> src=3 word reads 0x20001; any bit-reversal fails.
- Overrun: T_CYCLE=500 with busy 100 cycles -> frame longer than period; overrun_out pulses once per skipped trigger; no dv occurs outside a frame.
- Busy timeout: busy held low -> timeout_out pulses BUSY_TO cycles after CONVST ends; FSM back in IDLE, no dv, next trigger proceeds normally.
- Reset mid-READ: rst_in low after the 3rd dv -> outputs take reset values asynchronously (cs=1, sclk=1, dv=0); after release, the next frame starts at src 0.
- OS gating: change os_in during READ -> adc_os_out unchanged until IDLE, then equals new value before the next CONVST.
